// File: rtl/mon_pkg.sv
// Shared helpers for the multi-channel signed error monitor: width derivation and popcount.
package mon_pkg;

  localparam int unsigned MAX_CH = 16;
  localparam int unsigned PC_W   = 5;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [MAX_CH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/multi_serror_monitor_if.sv
// Stimulus-side bundle for the monitor: statistics clear, channel enables, measured and reference buses.
interface multi_serror_monitor_if #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DATAWIDTH = 32
);
  logic                          clear;
  logic [NUM_CH-1:0]             ch_en;
  logic [NUM_CH*DATAWIDTH-1:0]   meas;
  logic [NUM_CH*DATAWIDTH-1:0]   refd;

  modport master (output clear, ch_en, meas, refd);
  modport slave  (input  clear, ch_en, meas, refd);
endinterface

// File: rtl/mon_delay_line.sv
// Fixed-depth shift register that aligns one reference channel with the measured path.
module mon_delay_line #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned DEPTH     = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] i_d,
  output logic [DATAWIDTH-1:0] o_q
);

  logic [DATAWIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/multi_serror_monitor.sv
// NUM_CH-way tolerance compare of measured vs delayed reference outputs with
// post-reset valid gating, saturating error count and a frozen first-failure record.
module multi_serror_monitor
  import mon_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DATAWIDTH = 32,
  parameter bit          SIGNED    = 1'b1,
  parameter int unsigned DELAY     = 2,
  parameter int unsigned REF_LAT   = 0,
  parameter int unsigned TOL       = 0,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CYC_W     = 32
) (
  input  logic                            Clk,
  input  logic                            Rst,
  multi_serror_monitor_if.slave           bus,
  output logic                            valid,
  output logic [NUM_CH-1:0]               err,
  output logic                            err_sticky,
  output logic [CNT_W-1:0]                err_count,
  output logic                            first_valid,
  output logic [ch_idx_w(NUM_CH)-1:0]     first_ch,
  output logic [CYC_W-1:0]                first_cycle,
  output logic [DATAWIDTH-1:0]            first_meas,
  output logic [DATAWIDTH-1:0]            first_ref
);

  localparam int unsigned DW       = DATAWIDTH;
  localparam int unsigned DW1      = DATAWIDTH + 1;
  localparam int unsigned CH_IDX_W = ch_idx_w(NUM_CH);
  localparam int unsigned WAIT     = DELAY + REF_LAT;
  localparam int unsigned VCNT_W   = ch_idx_w(WAIT + 1);
  localparam int unsigned SUM_W    = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [DW:0]       TOL_V   = DW1'(TOL);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [CYC_W-1:0]    r_cyc;
  logic [VCNT_W-1:0]   r_vcnt;
  logic                r_valid;
  logic [NUM_CH-1:0]   r_err;
  logic                r_sticky;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_fvalid;
  logic [CH_IDX_W-1:0] r_fch;
  logic [CYC_W-1:0]    r_fcyc;
  logic [DW-1:0]       r_fmeas;
  logic [DW-1:0]       r_fref;

  logic [NUM_CH*DW-1:0] w_refd_dly;
  logic                 w_gate;
  logic [NUM_CH-1:0]    w_mis;
  logic [CH_IDX_W-1:0]  w_fch;
  logic [DW-1:0]        w_fmeas;
  logic [DW-1:0]        w_fref;
  logic [SUM_W-1:0]     w_sum;
  logic [CNT_W-1:0]     w_sat;

  // Reference alignment: a zero-latency setting is a straight wire.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    if (REF_LAT == 0) begin : g_wire
      assign w_refd_dly[g*DW +: DW] = bus.refd[g*DW +: DW];
    end else begin : g_dly
      mon_delay_line #(.DATAWIDTH(DW), .DEPTH(REF_LAT)) u_dly (
        .Clk (Clk),
        .Rst (Rst),
        .i_d (bus.refd[g*DW +: DW]),
        .o_q (w_refd_dly[g*DW +: DW])
      );
    end
  end

  assign w_gate = r_valid || (WAIT == 0);

  // Diff at DW+1 bits cannot overflow, so |diff| never exceeds 2^DW-1.
  always_comb begin
    logic [DW:0] v_m;
    logic [DW:0] v_r;
    logic [DW:0] v_d;
    logic [DW:0] v_a;
    w_mis = '0;
    v_m   = '0;
    v_r   = '0;
    v_d   = '0;
    v_a   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      v_m = {SIGNED & bus.meas[i*DW + DW-1],   bus.meas[i*DW +: DW]};
      v_r = {SIGNED & w_refd_dly[i*DW + DW-1], w_refd_dly[i*DW +: DW]};
      v_d = v_m - v_r;
      v_a = v_d[DW] ? (~v_d + DW1'(1)) : v_d;
      w_mis[i] = w_gate && bus.ch_en[i] && (v_a > TOL_V);
    end
  end

  // Lowest-index mismatch wins the first-failure slot.
  always_comb begin
    w_fch   = '0;
    w_fmeas = '0;
    w_fref  = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (w_mis[i]) begin
        w_fch   = CH_IDX_W'(i);
        w_fmeas = bus.meas[i*DW +: DW];
        w_fref  = w_refd_dly[i*DW +: DW];
      end
    end
  end

  assign w_sum = SUM_W'(r_cnt) + SUM_W'(popcount(MAX_CH'(w_mis)));
  assign w_sat = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_cyc    <= '0;
      r_vcnt   <= '0;
      r_valid  <= 1'b0;
      r_err    <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_fvalid <= 1'b0;
      r_fch    <= '0;
      r_fcyc   <= '0;
      r_fmeas  <= '0;
      r_fref   <= '0;
    end else begin
      r_cyc <= r_cyc + CYC_W'(1);
      if (!r_valid) begin
        if ((WAIT <= 1) || (r_vcnt == VCNT_W'(WAIT - 1))) r_valid <= 1'b1;
        else r_vcnt <= r_vcnt + VCNT_W'(1);
      end
      r_err <= w_mis;
      if (bus.clear) begin
        r_cnt    <= '0;
        r_sticky <= 1'b0;
        r_fvalid <= 1'b0;
        r_fch    <= '0;
        r_fcyc   <= '0;
        r_fmeas  <= '0;
        r_fref   <= '0;
      end else begin
        r_cnt <= w_sat;
        if (|w_mis) r_sticky <= 1'b1;
        if (!r_fvalid && (|w_mis)) begin
          r_fvalid <= 1'b1;
          r_fch    <= w_fch;
          r_fcyc   <= r_cyc;
          r_fmeas  <= w_fmeas;
          r_fref   <= w_fref;
        end
      end
    end
  end

  assign valid       = r_valid;
  assign err         = r_err;
  assign err_sticky  = r_sticky;
  assign err_count   = r_cnt;
  assign first_valid = r_fvalid;
  assign first_ch    = r_fch;
  assign first_cycle = r_fcyc;
  assign first_meas  = r_fmeas;
  assign first_ref   = r_fref;

endmodule

// File: doc/multi_serror_monitor.md
Name: multi_serror_monitor

Overview:
- Parametrised successor to the single-channel signed error monitor and delay-based valid generator used in circuit testbenches.
- Compares NUM_CH measured outputs against reference outputs, with a tolerance window. The reference is delayed so that its latency lines up with the measured path.
- Gating comes from an internal post-reset valid counter. Maintains per-channel, sticky, count and first-failure diagnostics.
- Sits in the bench between the reference and autogen DUT instances. Must also be synthesisable for on-board self-check.

Parameters:
- NUM_CH, 2, number of compared channels (1..16)
- DATAWIDTH, 32, bits per channel
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned
- DELAY, 2, cycles after reset release before the channel outputs are valid
- REF_LAT, 0, extra cycles the reference is delayed before compare (0..8)
- TOL, 0, maximum allowed |meas - ref| treated as a match
- CNT_W, 16, error counter width
- CYC_W, 32, cycle timestamp width

Ports:
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  synchronous reset, active-low
- clear  in  1  synchronous statistics clear
- ch_en  in  NUM_CH  per-channel compare enable
- meas  in  NUM_CH*DATAWIDTH  DUT outputs, channel i at [i*DATAWIDTH +: DATAWIDTH]
- refd  in  NUM_CH*DATAWIDTH  reference outputs, same packing
- valid  out  1  compare window active
- err  out  NUM_CH  registered per-cycle mismatch flags
- err_sticky  out  1  any mismatch since reset/clear
- err_count  out  CNT_W  saturating total mismatch count
- first_valid  out  1  first-failure record captured
- first_ch  out  max(1,$clog2(NUM_CH))  channel of first failure
- first_cycle  out  CYC_W  cycle timestamp of first failure
- first_meas, first_ref  out  DATAWIDTH  values at first failure

Behaviour:
- Reset (Rst=0 at an edge): every output is 0. The cycle counter, valid counter and ref delay line are zeroed.
- Cycle counter: increments every cycle Rst=1 and wraps at 2^CYC_W. The first edge with Rst=1 is cycle 0.
- Valid: asserts at the edge of cycle DELAY+REF_LAT-1, so it is high from cycle DELAY+REF_LAT onward.
  - DELAY+REF_LAT=0 gives valid=1 from cycle 0.
  - Stays high until the next reset.
- Ref delay line: REF_LAT-stage shift register per channel. REF_LAT=0 is a pure wire.
- Compare rule: channel i is evaluated in a cycle only when valid=1 and ch_en[i]=1.
  - diff is formed at DATAWIDTH+1 bits, sign-extended if SIGNED else zero-extended.
  - mismatch when |diff| > TOL.
  - TOL=0 means exact equality.
  - Most negative and most positive operands must not overflow.
- err[i]: registered mismatch, one cycle of latency. It is 0 whenever not evaluated.
- err_count: adds popcount(mismatches) in that cycle and saturates at 2^CNT_W-1, never wrapping.
- err_sticky: set on any mismatch; cleared only by reset or clear.
- First-failure record:
  - Captured on the first mismatching cycle while first_valid=0, with the lowest-index mismatching channel winning.
  - Stores that channel's meas, its delayed ref, and the cycle count of the compare cycle.
  - Then frozen until reset or clear.
- clear=1: zeroes err_count, err_sticky and the first_* outputs at that edge.
  - Mismatches in the same cycle are discarded, so clear wins.
  - Valid, the cycle counter, the delay line and err are unaffected.
- Reset mid-run: the valid window restarts; a fresh DELAY+REF_LAT wait is required.

Decomposition:
- Package mon_pkg: clog2 helper function, CH_IDX_W derivation, and a popcount function used for the count increment.
- Sub-module mon_delay_line (DATAWIDTH, DEPTH): per-channel ref shift register with the same reset as the parent, instantiated NUM_CH times via generate.
- Compare, count and capture logic live in the top level.

Test Plan:
- Reset hold, then DELAY=2, REF_LAT=0, meas=refd random:
  - valid rises at the cycle-1 edge.
  - err=0, err_count=0, first_valid=0 after 1000 cycles.
- Inject meas0 = refd0+1 at cycle 10, SIGNED=1, TOL=0:
  - err[0]=1 for exactly one cycle at cycle 11.
  - err_count=1, err_sticky=1.
  - first_ch=0, first_cycle=10, first_meas = ref+1.
- TOL=3, SIGNED=1, meas=32'h7FFFFFFF, refd=32'h80000000:
  - mismatch; no overflow false-pass.
  - With meas=-2 and refd=1, no error.
- NUM_CH=4, channels 1 and 3 mismatch at the same cycle:
  - err_count +2, first_ch=1.
  - ch_en[3]=0 suppresses err[3] and its count contribution.
- CNT_W=4, mismatch every cycle for 20 cycles:
  - err_count saturates at 15.
  - clear asserted in a mismatching cycle: the next err_count is 0, sticky=0, first_valid=0.
- REF_LAT=3, DELAY=1, meas equal to refd delayed by 3:
  - no errors; valid rises at the cycle-3 edge.
  - Rst=0 mid-run zeroes all outputs, and valid returns only 4 cycles after release.
